// File: rtl/matvec_pkg.sv
// Shared types and helpers for the sequential matrix-vector MAC block.
// Flat-bus slice helpers keep row-major element indexing in one place.
package matvec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int N_DEF  = 3;
  localparam int DW_DEF = 8;

  // Full-precision accumulator width: one 2*DW product plus growth for N terms.
  function automatic int calc_aw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int mat_lsb(input int i, input int j, input int n, input int dw);
    return (i * n + j) * dw;
  endfunction

  function automatic int vec_lsb(input int j, input int dw);
    return j * dw;
  endfunction

  function automatic int res_lsb(input int i, input int aw);
    return i * aw;
  endfunction

endpackage

// File: rtl/matvec_mac_lane.sv
// One multiply-accumulate lane holding a single row accumulator.
// Build option MATVEC_SIGNED_EN selects two's-complement operands and products.
module matvec_mac_lane #(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [AW-1:0] sum_o
);

  logic [AW-1:0] acc_q;
  logic [AW-1:0] prod_ext;

`ifdef MATVEC_SIGNED_EN
  logic signed [2*DW-1:0] prod;
  assign prod     = $signed(a_i) * $signed(b_i);
  // Size cast of a signed value sign-extends into the wider accumulator.
  assign prod_ext = AW'(prod);
`else
  logic [2*DW-1:0] prod;
  assign prod     = a_i * b_i;
  assign prod_ext = AW'(prod);
`endif

  // Accumulator value after this cycle's MAC; the top samples it on the last column.
  assign sum_o = acc_q + prod_ext;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/matvec_mac_seq.sv
// NxN matrix times N-vector, one column per cycle over N parallel MAC lanes.
// Valid/ready on both sides; MATVEC_SIGNED_EN selects signed arithmetic in the lanes.
module matvec_mac_seq
  import matvec_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = calc_aw(N, DW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*N*DW-1:0] mat_in,
  input  logic [N*DW-1:0]   vec_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*AW-1:0]   result,
  output logic              busy
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

  if (AW < 2 * DW) begin : g_aw_check
    $error("matvec_mac_seq: AW must be at least 2*DW");
  end
  if (N < 2) begin : g_n_check
    $error("matvec_mac_seq: N must be at least 2");
  end

  state_e              state_q,   state_d;
  logic [CW-1:0]       col_cnt_q, col_cnt_d;
  logic [N*N*DW-1:0]   mat_q,     mat_d;
  logic [N*DW-1:0]     vec_q,     vec_d;
  logic [N*AW-1:0]     result_q,  result_d;

  logic                accept;
  logic                mac_en;
  logic [DW-1:0]       vec_sel;
  logic [AW-1:0]       lane_sum [N];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

  assign accept  = in_valid && in_ready;
  assign mac_en  = (state_q == RUN);
  assign vec_sel = vec_q[vec_lsb(int'(col_cnt_q), DW) +: DW];

  for (genvar i = 0; i < N; i++) begin : g_lane
    matvec_mac_lane #(
      .DW(DW),
      .AW(AW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (accept),
      .en_i    (mac_en),
      .a_i     (mat_q[mat_lsb(i, int'(col_cnt_q), N, DW) +: DW]),
      .b_i     (vec_sel),
      .sum_o   (lane_sum[i])
    );
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    mat_d     = mat_q;
    vec_d     = vec_q;
    result_d  = result_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mat_d     = mat_in;
          vec_d     = vec_in;
          col_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (col_cnt_q == LAST_COL) begin
          col_cnt_d = '0;
          state_d   = DONE;
          for (int i = 0; i < N; i++) begin
            result_d[res_lsb(i, AW) +: AW] = lane_sum[i];
          end
        end else begin
          col_cnt_d = col_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset too, so an aborted transaction leaves no stale data visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
      mat_q     <= '0;
      vec_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      mat_q     <= mat_d;
      vec_q     <= vec_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_matvec_mac_seq.sv
// Directed bench for matvec_mac_seq with a result scoreboard fed by a reference model.
// Expectations follow MATVEC_SIGNED_EN when it is defined for the build.
module tb_matvec_mac_seq;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 18;
  localparam int MW = N * N * DW;
  localparam int VW = N * DW;
  localparam int RW = N * AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] mat_in;
  logic [VW-1:0] vec_in;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic          busy;

  int            tests = 0;
  int            fails = 0;
  logic [RW-1:0] sb_q [$];

  always #5 clk = ~clk;

  matvec_mac_seq #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mat_in    (mat_in),
    .vec_in    (vec_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] mk_mat(input int unsigned e [9]);
    logic [MW-1:0] m;
    for (int k = 0; k < N * N; k++) m[k*DW +: DW] = DW'(e[k]);
    return m;
  endfunction

  function automatic logic [VW-1:0] mk_vec(input int unsigned e [3]);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(e[k]);
    return v;
  endfunction

  function automatic logic [RW-1:0] model(input logic [MW-1:0] m, input logic [VW-1:0] v);
    logic [RW-1:0] r;
    logic [AW-1:0] acc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    longint        p;
    for (int i = 0; i < N; i++) begin
      acc = '0;
      for (int j = 0; j < N; j++) begin
        a = m[(i*N+j)*DW +: DW];
        b = v[j*DW +: DW];
`ifdef MATVEC_SIGNED_EN
        p = longint'($signed(a)) * longint'($signed(b));
`else
        p = longint'(a) * longint'(b);
`endif
        acc = acc + p[AW-1:0];
      end
      r[i*AW +: AW] = acc;
    end
    return r;
  endfunction

  task automatic send(input logic [MW-1:0] m, input logic [VW-1:0] v);
    int waited;
    waited   = 0;
    mat_in   = m;
    vec_in   = v;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("in_ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    sb_q.push_back(model(m, v));
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic pop_check(input string tag);
    logic [RW-1:0] exp;
    check({tag, "_sb_nonempty"}, (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check({tag, "_result"}, result, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [MW-1:0] m;
    logic [VW-1:0] v;
    int            ir_low;
    int            lat;
    logic          seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mat_in    = '0;
    vec_in    = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // Identity matrix: latency and in_ready-low window.
    out_ready = 1'b1;
    send(mk_mat('{1, 0, 0, 0, 1, 0, 0, 0, 1}), mk_vec('{1, 2, 3}));
    check("t1_busy", busy, 1);
    ir_low = 0;
    lat    = 0;
    while (!out_valid && lat < 50) begin
      if (!in_ready) ir_low++;
      tick();
      lat++;
    end
    check("t1_latency", lat, N);
    check("t1_result_const", result, {18'd3, 18'd2, 18'd1});
    pop_check("t1");
    if (!in_ready) ir_low++;
    tick();
    if (!in_ready) ir_low++;
    check("t1_in_ready_low_cycles", ir_low, N + 1);
    check("t1_out_valid_drop", out_valid, 0);

    // All-ones operands: largest unsigned sum.
    send('1, '1);
    wait_out("t2", N);
    pop_check("t2");
`ifndef MATVEC_SIGNED_EN
    check("t2_elem2", result[2*AW +: AW], 18'h2FA03);
`endif
    tick();

    // Operands changed after capture must not matter.
    send(mk_mat('{1, 2, 3, 4, 5, 6, 7, 8, 9}), mk_vec('{1, 0, 2}));
    mat_in = '0;
    vec_in = '0;
    wait_out("t3", N - 0);
    check("t3_result_const", result, {18'd25, 18'd16, 18'd7});
    pop_check("t3");
    tick();

    // Backpressure with a pending input held through DONE.
    out_ready = 1'b0;
    for (int k = 0; k < N * N; k++) m[k*DW +: DW] = DW'($urandom);
    for (int k = 0; k < N; k++)     v[k*DW +: DW] = DW'($urandom);
    send(m, v);
    wait_out("t4a", N);
    for (int k = 0; k < N * N; k++) m[k*DW +: DW] = DW'($urandom);
    for (int k = 0; k < N; k++)     v[k*DW +: DW] = DW'($urandom);
    mat_in   = m;
    vec_in   = v;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_in_ready", in_ready, 0);
      if (sb_q.size() != 0) check("t4_hold_result", result, sb_q[0]);
      tick();
    end
    pop_check("t4a");
    out_ready = 1'b1;
    tick();
    check("t4_out_drop", out_valid, 0);
    check("t4_not_accepted_in_done", in_ready, 1);
    tick();
    check("t4_accepted_next", busy, 1);
    in_valid = 1'b0;
    sb_q.push_back(model(m, v));
    wait_out("t4b", N);
    pop_check("t4b");
    tick();

    // Reset in the second RUN cycle aborts the transaction.
    send(mk_mat('{1, 2, 3, 4, 5, 6, 7, 8, 9}), mk_vec('{3, 3, 3}));
    tick();
    check("t5_in_run", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_result", result, 0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    check("t5_in_ready_after", in_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < N + 3; c++) begin
      tick();
      seen = seen | out_valid;
    end
    check("t5_no_out_valid", seen, 0);
    check("t5_result_zero", result, 0);

    // Mixed-sign bit patterns in row 0.
    send(mk_mat('{8'hFF, 8'h02, 8'hFD, 0, 0, 0, 0, 0, 0}), mk_vec('{4, 8'hFB, 6}));
    wait_out("t6", N);
    pop_check("t6");
`ifdef MATVEC_SIGNED_EN
    check("t6_elem0", result[AW-1:0], 18'h3FFE0);
`else
    check("t6_elem0", result[AW-1:0], 18'd3040);
`endif
    tick();

    // Random back-to-back transactions.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < N * N; k++) m[k*DW +: DW] = DW'($urandom);
      for (int k = 0; k < N; k++)     v[k*DW +: DW] = DW'($urandom);
      send(m, v);
      wait_out("t7", N);
      pop_check("t7");
      tick();
    end

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
